ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//   Shares RAM port A (1-cycle registered read, write-enable gated by enable) between two
//   requesters m0/m1 using round-robin arbitration with an optional bounded lock.
//   Presents a single-cycle req/gnt handshake and returns read data with an rvalid strobe.
//   Sits between the requesters (e.g. core and loader/DMA) and the RAM's port A.
//   Port B stays private to its own reader.
// PARAMETERS
//   AW        10  address width (1024-entry RAM)
//   DW         8  data width
//   MAX_LOCK   8  max consecutive locked grants while the other side waits (1..255)
// PORTS
//   clock       in   1   system clock, all state on rising edge
//   reset_n     in   1   asynchronous active-low reset
//   m0_req      in   1   m0 access request; hold with fields stable until m0_gnt
//   m0_we       in   1   1 = write, 0 = read
//   m0_lock     in   1   m0 asks to keep the port after this grant
//   m0_addr     in   AW  word address
//   m0_wdata    in   DW  write data
//   m0_gnt      out  1   request accepted this cycle (combinational)
//   m0_rvalid   out  1   m0 read data valid (registered)
//   m0_rdata    out  DW  read data, meaningful only while m0_rvalid
//   m1_*        --   --  identical set for requester 1
//   ram_en      out  1   to RAM a_en
//   ram_we      out  1   to RAM a_write_en
//   ram_addr    out  AW  to RAM a_addr
//   ram_wdata   out  DW  to RAM a_wdata
//   ram_rdata   in   DW  from RAM a_rdata
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     - last=1, so m0 wins first.
//     - lock_cnt=0, rpend=0, rsel=0, m0_rvalid=m1_rvalid=0.
//     - An in-flight read response is discarded.
//   Arbitration (combinational, every cycle):
//     - One requester: it wins.
//     - Both request: the side != last wins, unless the lock override applies.
//     - Lock override: requester[last] holds lock and req, and lock_cnt < MAX_LOCK;
//       then requester[last] wins.
//     - Winner X: mX_gnt=1, loser gnt=0.
//     - ram_en=1; ram_we/addr/wdata = X's fields.
//     - No request: ram_en=0, ram_we=0; ram_addr/ram_wdata driven 0.
//     - Never both gnt in one cycle; a requester never waits more than MAX_LOCK+1 cycles.
//   State update at posedge:
//     - On grant to X: last<=X.
//     - lock_cnt<=lock_cnt+1 when X==previous last AND other side requested AND override
//       used; otherwise lock_cnt<=0.
//     - Saturates at MAX_LOCK. At MAX_LOCK the override is blocked, so the other side
//       wins and lock_cnt resets to 0.
//     - rpend<=gnt & ~we; rsel<=winner.
//   Response:
//     - mX_rvalid = rpend & (rsel==X), exactly 1 cycle after a read grant.
//     - mX_rdata = ram_rdata (shared wire, no extra register).
//     - Write grants produce no rvalid.
//   Throughput:
//     - One access per cycle; back-to-back grants allowed.
//     - A read issued the cycle after a write to the same address returns the new data.
//   Hazards:
//     - Read and write to the same address in the same cycle is impossible on one port.
//     - Port B reading an address being written gets old data (RAM behaviour, not handled).
//   Requester changes fields while req=1 and gnt=0: allowed; the new values are used
//   at grant.
// TESTING
//   1 Reset then m0 read addr 0x010 alone -> m0_gnt same cycle; m0_rvalid next cycle,
//     m0_rdata = mem[0x010]; m1_rvalid stays 0.
//   2 m0 and m1 request continuously, no lock -> grants alternate m0,m1,m0,m1 from reset.
//   3 m1 writes 0xA5 to 0x3FF, then m0 reads 0x3FF next cycle -> m0_rdata=0xA5;
//     the write produces no rvalid.
//   4 m0 lock=1 + req held, m1 req held, MAX_LOCK=8 -> m0 gets 9 consecutive grants,
//     then m1 granted, then alternation resumes if lock persists.
//   5 Drop reset_n low mid-read (the cycle after m0 read grant) -> m0_rvalid=0
//     immediately; after release, first contested grant goes to m0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing RAM port A between two requesters, with a bounded
// lock that lets the last winner keep the port for up to MAX_LOCK extra grants.
module ram_port_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned CW = 8;

  logic          last_q, last_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          m0_rvalid_d, m1_rvalid_d;
  logic          any_req, both_req, lock_last, override, win;

  // Winner selection and RAM port mux; win=1 means m1.
  always_comb begin
    any_req     = m0_req | m1_req;
    both_req    = m0_req & m1_req;
    lock_last   = last_q ? m1_lock : m0_lock;
    override    = both_req & lock_last & (lock_cnt_q < CW'(MAX_LOCK));
    win         = m1_req;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    last_d      = last_q;
    lock_cnt_d  = '0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;

    if (both_req) begin
      win = override ? last_q : ~last_q;
    end

    if (any_req) begin
      m0_gnt    = ~win;
      m1_gnt    = win;
      ram_en    = 1'b1;
      ram_we    = win ? m1_we    : m0_we;
      ram_addr  = win ? m1_addr  : m0_addr;
      ram_wdata = win ? m1_wdata : m0_wdata;
      last_d    = win;
    end

    // Override is only possible below MAX_LOCK, so the counter saturates there.
    if (override) begin
      lock_cnt_d = lock_cnt_q + CW'(1);
    end

    m0_rvalid_d = m0_gnt & ~ram_we;
    m1_rvalid_d = m1_gnt & ~ram_we;
  end

  // Arbitration history and read-response strobes (one cycle after a read grant).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
    end else begin
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      m0_rvalid  <= m0_rvalid_d;
      m1_rvalid  <= m1_rvalid_d;
    end
  end

  assign m0_rdata = ram_rdata;
  assign m1_rdata = ram_rdata;

endmodule
